led_blink_bank: RTL and testbench

LED_BLINK_BANK -- requirements
Module: led_blink_bank

---
 rtl/led_blink_bank.sv | 128 ++++++++++++
 tb/tb_led_blink_bank.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/led_blink_bank.sv
// Bank of independent LED channels, each OFF, ON, free-running BLINK or ONESHOT,
// configured one channel per write and realignable with a global restart strobe.
module led_blink_bank #(
    parameter int                NCH      = 4,
    parameter int                CNT_W    = 25,
    parameter logic [CNT_W-1:0]  DEF_HALF = 25'd24_999_999,
    parameter int                CH_W     = 2
) (
    input  logic             Clk50M,
    input  logic             Rst,
    input  logic             cfg_wr,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_half,
    input  logic             sync_restart,
    output logic             cfg_ack,
    output logic             cfg_err,
    output logic [NCH-1:0]   led,
    output logic [NCH-1:0]   toggle_tick
);

    typedef enum logic [1:0] {
        M_OFF     = 2'b00,
        M_ON      = 2'b01,
        M_BLINK   = 2'b10,
        M_ONESHOT = 2'b11
    } mode_e;

    localparam logic [CH_W:0] NCH_L = (CH_W + 1)'(NCH);

    mode_e            r_mode [NCH];
    logic [CNT_W-1:0] r_half [NCH];
    logic [CNT_W-1:0] r_cnt  [NCH];
    logic [NCH-1:0]   r_led;
    logic [NCH-1:0]   r_tick;
    logic             r_ack;
    logic             r_err;

    logic             w_ch_bad;
    logic [NCH-1:0]   w_wr_hit;
    logic [NCH-1:0]   w_exp;

    assign w_ch_bad = ({1'b0, cfg_ch} >= NCH_L);

    // Per-channel write select and counter expiry decode
    always_comb begin
        w_wr_hit = '0;
        w_exp    = '0;
        for (int i = 0; i < NCH; i++) begin
            w_wr_hit[i] = cfg_wr && !w_ch_bad && (cfg_ch == CH_W'(i));
            w_exp[i]    = (r_cnt[i] == r_half[i]);
        end
    end

    // Channel state: a write to a channel overrides the restart for that channel only
    always_ff @(posedge Clk50M or posedge Rst) begin
        if (Rst) begin
            r_led  <= '1;
            r_tick <= '0;
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                r_mode[i] <= M_BLINK;
                r_half[i] <= DEF_HALF;
                r_cnt[i]  <= '0;
            end
        end else begin
            r_ack <= cfg_wr;
            r_err <= cfg_wr && w_ch_bad;
            for (int i = 0; i < NCH; i++) begin
                r_tick[i] <= 1'b0;
                if (w_wr_hit[i]) begin
                    r_mode[i] <= mode_e'(cfg_mode);
                    r_half[i] <= cfg_half;
                    r_cnt[i]  <= '0;
                    r_led[i]  <= (cfg_mode != 2'b00);
                end else if (sync_restart) begin
                    r_cnt[i] <= '0;
                    if (r_mode[i] == M_BLINK || r_mode[i] == M_ONESHOT) begin
                        r_led[i] <= 1'b1;
                    end else begin
                        r_led[i] <= r_led[i];
                    end
                end else begin
                    case (r_mode[i])
                        M_OFF: begin
                            r_cnt[i] <= '0;
                            r_led[i] <= 1'b0;
                        end
                        M_ON: begin
                            r_cnt[i] <= '0;
                            r_led[i] <= 1'b1;
                        end
                        M_BLINK: begin
                            if (w_exp[i]) begin
                                r_cnt[i]  <= '0;
                                r_led[i]  <= ~r_led[i];
                                r_tick[i] <= 1'b1;
                            end else begin
                                r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                            end
                        end
                        M_ONESHOT: begin
                            if (w_exp[i]) begin
                                r_cnt[i]  <= '0;
                                r_led[i]  <= 1'b0;
                                r_tick[i] <= 1'b1;
                                r_mode[i] <= M_OFF;
                            end else begin
                                r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                            end
                        end
                        default: begin
                            r_cnt[i] <= '0;
                            r_led[i] <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign cfg_ack     = r_ack;
    assign cfg_err     = r_err;
    assign led         = r_led;
    assign toggle_tick = r_tick;

endmodule

// File: tb/tb_led_blink_bank.sv
// Directed bench for led_blink_bank: a 4-channel build plus a 3-channel build
// sharing the same stimulus so out-of-range channel writes can be observed.
module tb_led_blink_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_wr = 1'b0;
    logic [1:0] cfg_ch = 2'd0;
    logic [1:0] cfg_mode = 2'd0;
    logic [7:0] cfg_half = 8'd0;
    logic       sync_restart = 1'b0;

    logic       ack_a, err_a, ack_b, err_b;
    logic [3:0] led_a, tick_a;
    logic [2:0] led_b, tick_b;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n   = 0;

    always #5 clk = ~clk;

    led_blink_bank #(.NCH(4), .CNT_W(8), .DEF_HALF(8'd9), .CH_W(2)) u_dut (
        .Clk50M(clk), .Rst(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_half(cfg_half), .sync_restart(sync_restart),
        .cfg_ack(ack_a), .cfg_err(err_a), .led(led_a), .toggle_tick(tick_a)
    );

    led_blink_bank #(.NCH(3), .CNT_W(8), .DEF_HALF(8'd9), .CH_W(2)) u_dut3 (
        .Clk50M(clk), .Rst(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_half(cfg_half), .sync_restart(sync_restart),
        .cfg_ack(ack_b), .cfg_err(err_b), .led(led_b), .toggle_tick(tick_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic step_to(input int n);
        while (edge_n < n) step();
    endtask

    task automatic wr(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] half);
        cfg_wr   = 1'b1;
        cfg_ch   = ch;
        cfg_mode = mode;
        cfg_half = half;
    endtask

    initial begin
        // reset state
        step(); step(); step();
        check("rst_led", 32'(led_a), 32'h0000_000f);
        check("rst_tick", 32'(tick_a), 32'h0);
        check("rst_ack", 32'(ack_a), 32'h0);
        check("rst_err", 32'(err_a), 32'h0);
        check("rst_led_b", 32'(led_b), 32'h7);
        rst = 1'b0;
        edge_n = 0;

        // default blink cadence after release
        step_to(1);  check("rel_e1_led", 32'(led_a), 32'hf);
        step_to(9);  check("rel_e9_led", 32'(led_a), 32'hf);
                     check("rel_e9_tick", 32'(tick_a), 32'h0);
        step_to(10); check("rel_e10_led", 32'(led_a), 32'h0);
                     check("rel_e10_tick", 32'(tick_a), 32'hf);
        step_to(11); check("rel_e11_tick", 32'(tick_a), 32'h0);
        step_to(20); check("rel_e20_led", 32'(led_a), 32'hf);
                     check("rel_e20_tick", 32'(tick_a), 32'hf);

        // ch2 BLINK half=0
        wr(2'd2, 2'b10, 8'd0);
        step_to(21); cfg_wr = 1'b0;
        check("b0_ack", 32'(ack_a), 32'h1);
        check("b0_err", 32'(err_a), 32'h0);
        check("b0_e21_led", 32'(led_a), 32'hf);
        step_to(22); check("b0_e22_led", 32'(led_a), 32'hb);
                     check("b0_e22_tick", 32'(tick_a), 32'h4);
                     check("b0_e22_ack", 32'(ack_a), 32'h0);
        step_to(23); check("b0_e23_led", 32'(led_a), 32'hf);
        step_to(29); check("b0_e29_led", 32'(led_a), 32'hf);
                     check("b0_e29_tick", 32'(tick_a), 32'h4);
        step_to(30); check("b0_e30_led", 32'(led_a), 32'h0);
                     check("b0_e30_tick", 32'(tick_a), 32'hf);

        // ch1 ONESHOT half=4
        wr(2'd1, 2'b11, 8'd4);
        step_to(31); cfg_wr = 1'b0;
        check("os_ack", 32'(ack_a), 32'h1);
        check("os_e31_led", 32'(led_a), 32'h6);
        step_to(35); check("os_e35_led", 32'(led_a), 32'h6);
                     check("os_e35_tick", 32'(tick_a), 32'h4);
        step_to(36); check("os_e36_led", 32'(led_a), 32'h0);
                     check("os_e36_tick", 32'(tick_a), 32'h6);
        step_to(37); check("os_e37_led", 32'(led_a), 32'h4);
                     check("os_e37_tick", 32'(tick_a), 32'h4);

        // ch0 ON then ch3 OFF back to back; ch3 is out of range on the 3-channel build
        wr(2'd0, 2'b01, 8'd7);
        step_to(38);
        check("on_ack", 32'(ack_a), 32'h1);
        check("on_led", 32'(led_a), 32'h1);
        check("on_err_b", 32'(err_b), 32'h0);
        wr(2'd3, 2'b00, 8'd7);
        step_to(39); cfg_wr = 1'b0;
        check("off_ack", 32'(ack_a), 32'h1);
        check("off_err_a", 32'(err_a), 32'h0);
        check("off_led", 32'(led_a), 32'h5);
        check("off_tick", 32'(tick_a), 32'h4);
        check("bad_ack_b", 32'(ack_b), 32'h1);
        check("bad_err_b", 32'(err_b), 32'h1);
        check("bad_led_b", 32'(led_b), 32'h5);
        step_to(40); check("onoff_e40_led", 32'(led_a), 32'h1);
                     check("onoff_e40_tick", 32'(tick_a), 32'h4);
                     check("onoff_e40_ack", 32'(ack_a), 32'h0);
                     check("onoff_e40_err_b", 32'(err_b), 32'h0);
        step_to(50); check("onoff_e50_led", 32'(led_a), 32'h1);
                     check("onoff_e50_tick", 32'(tick_a), 32'h4);

        // restart with simultaneous write to ch1 mid-period
        wr(2'd3, 2'b10, 8'd9);
        step_to(51);
        wr(2'd1, 2'b10, 8'd9);
        step_to(52); cfg_wr = 1'b0;
        step_to(55);
        wr(2'd1, 2'b11, 8'd2);
        sync_restart = 1'b1;
        step_to(56); cfg_wr = 1'b0; sync_restart = 1'b0;
        check("sr_ack", 32'(ack_a), 32'h1);
        check("sr_e56_led", 32'(led_a), 32'hf);
        check("sr_e56_tick", 32'(tick_a), 32'h0);
        step_to(57); check("sr_e57_led", 32'(led_a), 32'hb);
                     check("sr_e57_tick", 32'(tick_a), 32'h4);
        step_to(59); check("sr_e59_led", 32'(led_a), 32'h9);
                     check("sr_e59_tick", 32'(tick_a), 32'h6);
        step_to(65); check("sr_e65_led", 32'(led_a), 32'h9);
                     check("sr_e65_tick", 32'(tick_a), 32'h4);
        step_to(66); check("sr_e66_led", 32'(led_a), 32'h5);
                     check("sr_e66_tick", 32'(tick_a), 32'hc);

        // reset during a ONESHOT and during a pending write
        wr(2'd1, 2'b11, 8'd9);
        step_to(67); cfg_wr = 1'b0;
        step_to(69);
        wr(2'd0, 2'b00, 8'd3);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_led", 32'(led_a), 32'hf);
        check("rst_mid_tick", 32'(tick_a), 32'h0);
        step_to(70);
        check("rst_mid_ack", 32'(ack_a), 32'h0);
        cfg_wr = 1'b0;
        rst = 1'b0;
        step_to(71);
        check("post_rst_ack", 32'(ack_a), 32'h0);
        check("post_rst_led", 32'(led_a), 32'hf);
        check("post_rst_tick", 32'(tick_a), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
